// File: rtl/boot_pkg.sv
// Shared types and default constants for the boot loader / memory-port arbiter.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

package boot_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WRITE = 2'd1,
    RUN   = 2'd2
  } boot_state_t;

  localparam int unsigned DEFAULT_LOAD_BASE   = 32'h200;
  localparam logic [15:0] DEFAULT_TERM_WORD   = 16'hffff;
  localparam logic [15:0] DEFAULT_RELOAD_WORD = 16'hfffe;

endpackage

// File: rtl/byte_pair_assembler.sv
// Pairs consecutive UART bytes into a big-endian 16-bit word with a one-cycle valid pulse.
module byte_pair_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_wr,
  output logic [15:0] word,
  output logic        word_v
);

  logic       phase_q;
  logic [7:0] hi_q;

  // rx_data_wr is a strobe with no back-pressure: every strobe is consumed the cycle it
  // arrives, and word_v is a one-cycle pulse the consumer must act on immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 1'b0;
      hi_q    <= 8'h00;
      word    <= 16'h0000;
      word_v  <= 1'b0;
    end else begin
      word_v <= 1'b0;
      if (rx_data_wr) begin
        phase_q <= ~phase_q;
        if (!phase_q) begin
          hi_q <= rx_data;
        end else begin
          word   <= {hi_q, rx_data};
          word_v <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/boot_loader_ctrl.sv
// Loads a program from UART into memory while the CPU is held in reset, then hands
// the memory port to the CPU and forwards further UART words as its input register.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module boot_loader_ctrl
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = `ADDR_WIDTH,
  parameter int unsigned LOAD_BASE   = DEFAULT_LOAD_BASE,
  parameter logic [15:0] TERM_WORD   = DEFAULT_TERM_WORD,
  parameter logic [15:0] RELOAD_WORD = DEFAULT_RELOAD_WORD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_data_wr,
  input  logic [ADDR_WIDTH-1:0] cpu_mem_addr,
  input  logic                  cpu_mem_wr,
  input  logic                  cpu_mem_byt,
  input  logic [15:0]           cpu_wr_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr,
  output logic                  mem_byt,
  output logic [15:0]           mem_wr_data,
  output logic                  cpu_rst,
  output logic [15:0]           uart_in,
  output logic                  uart_in_v,
  output logic                  loading,
  output logic                  load_ovf
);

  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = LOAD_BASE[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};

  logic [15:0] word;
  logic        word_v;

  byte_pair_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_data_wr (rx_data_wr),
    .word       (word),
    .word_v     (word_v)
  );

  boot_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] load_addr_q, load_addr_d;
  logic                  full_q, full_d;
  logic                  load_ovf_q, load_ovf_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic [15:0]           uart_in_q, uart_in_d;
  logic                  uart_in_v_q, uart_in_v_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      load_addr_q <= BASE_ADDR;
      full_q      <= 1'b0;
      load_ovf_q  <= 1'b0;
      cpu_rst_q   <= 1'b1;
      uart_in_q   <= 16'h0000;
      uart_in_v_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_addr_q <= load_addr_d;
      full_q      <= full_d;
      load_ovf_q  <= load_ovf_d;
      cpu_rst_q   <= cpu_rst_d;
      uart_in_q   <= uart_in_d;
      uart_in_v_q <= uart_in_v_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    full_d      = full_q;
    load_ovf_d  = load_ovf_q;
    cpu_rst_d   = cpu_rst_q;
    uart_in_d   = uart_in_q;
    uart_in_v_d = 1'b0;
    case (state_q)
      LOAD: begin
        if (word_v) begin
          if (word == TERM_WORD) begin
            state_d   = RUN;
            cpu_rst_d = 1'b0;
          end else if (!full_q) begin
            state_d = WRITE;
          end else begin
            load_ovf_d = 1'b1;
          end
        end
      end
      WRITE: begin
        state_d = LOAD;
        // The top word is the last slot; the pointer parks there instead of wrapping.
        if (load_addr_q == LAST_ADDR) begin
          full_d = 1'b1;
        end else begin
          load_addr_d = load_addr_q + ADDR_WIDTH'(2);
        end
      end
      RUN: begin
        if (word_v) begin
          uart_in_d   = word;
          uart_in_v_d = 1'b1;
          if (word == RELOAD_WORD) begin
            state_d     = LOAD;
            load_addr_d = BASE_ADDR;
            full_d      = 1'b0;
            load_ovf_d  = 1'b0;
            cpu_rst_d   = 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    if (state_q == RUN) begin
      mem_addr    = cpu_mem_addr;
      mem_wr      = cpu_mem_wr;
      mem_byt     = cpu_mem_byt;
      mem_wr_data = cpu_wr_data;
    end else begin
      mem_addr    = load_addr_q;
      mem_wr      = (state_q == WRITE);
      mem_byt     = 1'b0;
      mem_wr_data = word;
    end
  end

  assign cpu_rst   = cpu_rst_q;
  assign uart_in   = uart_in_q;
  assign uart_in_v = uart_in_v_q;
  assign loading   = (state_q != RUN);
  assign load_ovf  = load_ovf_q;

endmodule
